// File: rtl/jtpopeye_sdram.sv
// jtpopeye_sdram: single-bank SDRAM controller returning two consecutive 16-bit words per read.
// Download writes are compiled in only when JTPOPEYE_SDRAM_WRITE_EN is defined.
module jtpopeye_sdram #(
  parameter int CL             = 2,
  parameter int INIT_WAIT      = 2400,
  parameter int REFRESH_PERIOD = 390
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic        data_rdy,
  output logic [31:0] data_read,
  input  logic        refresh_en,
  output logic        loop_rst,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic        prog_we,
  output logic        prog_rdy,
  input  logic [15:0] SDRAM_DQ_IN,
  output logic [15:0] SDRAM_DQ_OUT,
  output logic        SDRAM_DQ_OE,
  output logic [12:0] SDRAM_A,
  output logic [1:0]  SDRAM_BA,
  output logic [3:0]  SDRAM_CMD,
  output logic [1:0]  SDRAM_DQM
);
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100,
                         PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  typedef enum logic [2:0] {INIT, IDLE, READ, WRITE, REFRESH} state_t;
  state_t state;
  logic [31:0] cnt, rcnt;
  logic [8:0] col;
  logic [15:0] word0;
  logic pending, rf_tick, rf_go, rd_go;
  assign SDRAM_BA = 2'b00;
  assign SDRAM_DQM = 2'b00;
  assign rf_tick = rcnt == REFRESH_PERIOD - 1;
  assign rf_go = pending && refresh_en;
`ifdef JTPOPEYE_SDRAM_WRITE_EN
  logic pw;
  logic [21:0] paddr;
  logic [15:0] pdata;
  assign rd_go = sdram_req && !downloading;
`else
  logic unused;
  assign unused = ^{downloading, prog_addr, prog_data, prog_we};
  assign rd_go = sdram_req;
  assign prog_rdy = 1'b0;
  assign SDRAM_DQ_OUT = 16'h0000;
  assign SDRAM_DQ_OE = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      rcnt      <= '0;
      pending   <= 1'b0;
      loop_rst  <= 1'b1;
      SDRAM_CMD <= NOP;
      SDRAM_A   <= '0;
      sdram_ack <= 1'b0;
      data_rdy  <= 1'b0;
      data_read <= '0;
      col       <= '0;
      word0     <= '0;
`ifdef JTPOPEYE_SDRAM_WRITE_EN
      pw           <= 1'b0;
      prog_rdy     <= 1'b0;
      SDRAM_DQ_OE  <= 1'b0;
      SDRAM_DQ_OUT <= '0;
`endif
    end else begin
      SDRAM_CMD <= NOP;
      sdram_ack <= 1'b0;
      data_rdy  <= 1'b0;
      cnt       <= cnt + 32'd1;
      rcnt      <= rf_tick ? '0 : rcnt + 32'd1;
`ifdef JTPOPEYE_SDRAM_WRITE_EN
      prog_rdy    <= 1'b0;
      SDRAM_DQ_OE <= 1'b0;
      if (prog_we) begin
        pw    <= 1'b1;
        paddr <= prog_addr;
        pdata <= prog_data;
      end else if (state == IDLE && !rf_go) pw <= 1'b0;
`endif
      case (state)
        INIT: begin
          SDRAM_CMD <= cnt == INIT_WAIT ? PRE :
                       (cnt == INIT_WAIT + 1 || cnt == INIT_WAIT + 9) ? REF :
                       cnt == INIT_WAIT + 17 ? MRS : NOP;
          SDRAM_A   <= cnt == INIT_WAIT ? 13'h400 : cnt == INIT_WAIT + 17 ? 13'(CL << 4) : 13'h000;
          if (cnt == INIT_WAIT + 20) begin
            loop_rst <= 1'b0;
            state    <= IDLE;
          end
        end
        IDLE: begin
          cnt <= '0;
          if (rf_go) begin
            SDRAM_CMD <= REF;
            state     <= REFRESH;
          end
`ifdef JTPOPEYE_SDRAM_WRITE_EN
          else if (pw) begin
            SDRAM_CMD <= ACT;
            SDRAM_A   <= paddr[21:9];
            col       <= paddr[8:0];
            state     <= WRITE;
          end
`endif
          else if (rd_go) begin
            SDRAM_CMD <= ACT;
            SDRAM_A   <= sdram_addr[21:9];
            col       <= sdram_addr[8:0];
            sdram_ack <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          // second column wraps inside the row; A10 on it closes the row
          SDRAM_CMD <= (cnt == 32'd1 || cnt == 32'd2) ? RD : NOP;
          SDRAM_A   <= {2'b00, cnt == 32'd2, 1'b0, cnt == 32'd2 ? col + 9'd1 : col};
          if (cnt == CL + 2) word0 <= SDRAM_DQ_IN;
          if (cnt == CL + 3) begin
            data_read <= {SDRAM_DQ_IN, word0};
            data_rdy  <= 1'b1;
          end
          if (cnt == CL + 4) state <= IDLE;
        end
        REFRESH: begin
          if (cnt == 32'd6) begin
            state   <= IDLE;
            pending <= 1'b0;
          end
        end
`ifdef JTPOPEYE_SDRAM_WRITE_EN
        WRITE: begin
          SDRAM_CMD    <= cnt == 32'd1 ? WR : NOP;
          SDRAM_A      <= {4'b0010, col};
          SDRAM_DQ_OE  <= cnt == 32'd1;
          SDRAM_DQ_OUT <= pdata;
          if (cnt == 32'd4) begin
            prog_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
      // a new refresh tick outranks the clear at the end of REFRESH
      if (rf_tick) pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jtpopeye_sdram.sv
// tb_jtpopeye_sdram: directed init, read, refresh, download and reset checks against a small SDRAM model.
module tb_jtpopeye_sdram;
  localparam int CL = 2, INIT_WAIT = 10, REFRESH_PERIOD = 200;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100,
                         PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  logic clk = 1'b0, rst = 1'b1;
  logic sdram_req = 1'b0, refresh_en = 1'b0, downloading = 1'b0, prog_we = 1'b0;
  logic [21:0] sdram_addr = '0, prog_addr = '0;
  logic [15:0] prog_data = '0, SDRAM_DQ_IN = '0, SDRAM_DQ_OUT;
  logic sdram_ack, data_rdy, loop_rst, prog_rdy, SDRAM_DQ_OE;
  logic [31:0] data_read;
  logic [12:0] SDRAM_A;
  logic [1:0] SDRAM_BA, SDRAM_DQM;
  logic [3:0] SDRAM_CMD;
  int total = 0, bad = 0;

  jtpopeye_sdram #(.CL(CL), .INIT_WAIT(INIT_WAIT), .REFRESH_PERIOD(REFRESH_PERIOD)) dut (
    .clk(clk), .rst(rst), .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en), .loop_rst(loop_rst),
    .downloading(downloading), .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .prog_rdy(prog_rdy), .SDRAM_DQ_IN(SDRAM_DQ_IN), .SDRAM_DQ_OUT(SDRAM_DQ_OUT),
    .SDRAM_DQ_OE(SDRAM_DQ_OE), .SDRAM_A(SDRAM_A), .SDRAM_BA(SDRAM_BA), .SDRAM_CMD(SDRAM_CMD),
    .SDRAM_DQM(SDRAM_DQM)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mw(input logic [21:0] a);
    return a == 22'h000A05 ? 16'h1234 : a == 22'h000A06 ? 16'h5678 : a[15:0] ^ 16'hC3C3;
  endfunction

  // chip model: data for a READ appears on DQ CL cycles after the command
  logic [15:0] hist [0:3];
  logic [12:0] mrow = '0;
  always @(negedge clk) begin
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = 16'h0000;
    if (SDRAM_CMD == ACT) mrow = SDRAM_A;
    if (SDRAM_CMD == RD) hist[0] = mw({mrow, SDRAM_A[8:0]});
    SDRAM_DQ_IN = hist[CL];
  end

  typedef struct {
    logic [21:0] addr;
    logic [12:0] row;
    logic [8:0]  c0, c1;
    logic [31:0] data;
  } vec_t;
  vec_t vec [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_read(input int v, output int ack_at, output int ref_at);
    sdram_req = 1'b1;
    sdram_addr = vec[v].addr;
    ack_at = 0;
    ref_at = 0;
    for (int i = 1; i <= 40 && ack_at == 0; i++) begin
      @(negedge clk);
      if (SDRAM_CMD == REF && ref_at == 0) ref_at = i;
      if (sdram_ack) ack_at = i;
    end
    sdram_req = 1'b0;
    chk("ack_seen", 32'(ack_at != 0), 1);
    if (ack_at == 0) return;
    chk("act_cmd", SDRAM_CMD, ACT);
    chk("act_row", SDRAM_A, vec[v].row);
    @(negedge clk);
    chk("t1_nop", SDRAM_CMD, NOP);
    chk("ack_pulse", sdram_ack, 0);
    @(negedge clk);
    chk("rd0_cmd", SDRAM_CMD, RD);
    chk("rd0_a", SDRAM_A, {4'b0000, vec[v].c0});
    @(negedge clk);
    chk("rd1_cmd", SDRAM_CMD, RD);
    chk("rd1_a", SDRAM_A, {4'b0010, vec[v].c1});
    for (int k = 4; k < CL + 4; k++) begin
      @(negedge clk);
      chk("rdy_early", data_rdy, 0);
      chk("gap_nop", SDRAM_CMD, NOP);
    end
    @(negedge clk);
    chk("rdy", data_rdy, 1);
    chk("data", data_read, vec[v].data);
    @(negedge clk);
    chk("rdy_pulse", data_rdy, 0);
    chk("data_hold", data_read, vec[v].data);
  endtask

  task automatic run_init(input logic hold_req);
    int pre_at, ref1, ref2, nref, mrs_at, fall_at, acks, rdys;
    logic [12:0] pre_a, mrs_a;
    pre_at = 0; ref1 = 0; ref2 = 0; nref = 0; mrs_at = 0; fall_at = 0; acks = 0; rdys = 0;
    pre_a = '0; mrs_a = '0;
    @(negedge clk);
    rst = 1'b1;
    sdram_req = hold_req;
    sdram_addr = 22'h000A05;
    repeat (2) @(negedge clk);
    chk("rst_loop_rst", loop_rst, 1);
    chk("rst_cmd", SDRAM_CMD, NOP);
    chk("rst_ack", sdram_ack, 0);
    chk("rst_rdy", data_rdy, 0);
    chk("rst_data", data_read, 0);
    chk("rst_oe", SDRAM_DQ_OE, 0);
    chk("rst_a", SDRAM_A, 0);
    chk("rst_prog_rdy", prog_rdy, 0);
    rst = 1'b0;
    for (int n = 1; n <= 80 && fall_at == 0; n++) begin
      @(negedge clk);
      if (sdram_ack) acks++;
      if (data_rdy) rdys++;
      if (SDRAM_CMD == PRE) begin pre_at = n; pre_a = SDRAM_A; end
      if (SDRAM_CMD == REF) begin
        if (nref == 0) ref1 = n; else ref2 = n;
        nref++;
      end
      if (SDRAM_CMD == MRS) begin mrs_at = n; mrs_a = SDRAM_A; end
      if (!loop_rst) begin fall_at = n; sdram_req = 1'b0; end
    end
    chk("init_pre_at", pre_at, INIT_WAIT + 1);
    chk("init_pre_a10", pre_a, 13'h400);
    chk("init_ref1", ref1 - pre_at, 1);
    chk("init_ref2", ref2 - ref1, 8);
    chk("init_nref", nref, 2);
    chk("init_mrs", mrs_at - ref2, 8);
    chk("init_mrs_a", mrs_a, 13'h020);
    chk("init_fall", fall_at - mrs_at, 3);
    chk("init_no_ack", acks, 0);
    chk("init_no_rdy", rdys, 0);
  endtask

  initial begin
    int a, r, t0, t1, td, got, nref;
    int acks, nwr, noe, nrdy, act_at, wr_at, oe_at, rdy_at;
    logic [12:0] act_a, wr_a;
    logic [15:0] wr_d;
    vec[0] = '{22'h000A05, 13'h0005, 9'h005, 9'h006, 32'h56781234};
    vec[1] = '{22'h0001FF, 13'h0000, 9'h1FF, 9'h000, 32'hC3C3C23C};
    vec[2] = '{22'h3FFFFF, 13'h1FFF, 9'h1FF, 9'h000, 32'h3DC33C3C};
    vec[3] = '{22'h123456, 13'h091A, 9'h056, 9'h057, 32'hF794F795};
    vec[4] = '{22'h000200, 13'h0001, 9'h000, 9'h001, 32'hC1C2C1C3};
    run_init(1'b1);
    for (int v = 0; v < 5; v++) begin
      do_read(v, a, r);
      chk("ack_at", a, 1);
    end
    // requester keeps req high across two accesses: second ACT waits 2 cycles after data_rdy
    sdram_req = 1'b1;
    sdram_addr = vec[3].addr;
    t0 = 0; t1 = 0; td = 0; got = 0;
    for (int i = 1; i <= 60 && t1 == 0; i++) begin
      @(negedge clk);
      if (sdram_ack) begin
        if (t0 == 0) t0 = i;
        else begin t1 = i; sdram_req = 1'b0; end
      end
      if (data_rdy && td == 0) td = i;
    end
    sdram_req = 1'b0;
    chk("trp_rdy_at", td - t0, CL + 4);
    chk("trp_gap", t1 - td, 2);
    for (int i = 1; i <= 20 && got == 0; i++) begin
      @(negedge clk);
      if (data_rdy) got = 1;
    end
    chk("trp_rdy2", got, 1);
    chk("trp_data", data_read, vec[3].data);
    // refresh pending with refresh_en=0 is withheld
    nref = 0;
    repeat (REFRESH_PERIOD + 10) begin
      @(negedge clk);
      if (SDRAM_CMD == REF) nref++;
    end
    chk("ref_withheld", nref, 0);
    refresh_en = 1'b1;
    do_read(0, a, r);
    chk("ref_first", r, 1);
    chk("ref_ack_delay", a, 9);
    refresh_en = 1'b0;
    repeat (REFRESH_PERIOD + 10) @(negedge clk);
    do_read(2, a, r);
    chk("noref_ack_at", a, 1);
    chk("noref_no_ref", r, 0);
    refresh_en = 1'b1;
    r = 0;
    for (int i = 1; i <= 5 && r == 0; i++) begin
      @(negedge clk);
      if (SDRAM_CMD == REF) r = i;
    end
    chk("ref_late", r, 1);
    repeat (8) @(negedge clk);
    refresh_en = 1'b0;
    // download write with a concurrent read request
    acks = 0; nwr = 0; noe = 0; nrdy = 0; act_at = 0; wr_at = 0; oe_at = 0; rdy_at = 0;
    act_a = '1; wr_a = '0; wr_d = '0;
    downloading = 1'b1;
    sdram_req = 1'b1;
    sdram_addr = 22'h000A05;
    prog_addr = 22'h000003;
    prog_data = 16'hBEEF;
    prog_we = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      prog_we = 1'b0;
      if (sdram_ack) begin acks++; sdram_req = 1'b0; end
      if (SDRAM_CMD == ACT) begin act_at = i; act_a = SDRAM_A; end
      if (SDRAM_CMD == WR) begin nwr++; wr_at = i; wr_a = SDRAM_A; wr_d = SDRAM_DQ_OUT; end
      if (SDRAM_DQ_OE) begin noe++; oe_at = i; end
      if (prog_rdy) begin nrdy++; rdy_at = i; end
    end
    sdram_req = 1'b0;
    downloading = 1'b0;
`ifdef JTPOPEYE_SDRAM_WRITE_EN
    chk("wr_no_ack", acks, 0);
    chk("wr_count", nwr, 1);
    chk("wr_a", wr_a, 13'h403);
    chk("wr_data", wr_d, 16'hBEEF);
    chk("wr_act_row", act_a, 13'h0000);
    chk("wr_act_gap", wr_at - act_at, 2);
    chk("wr_oe_count", noe, 1);
    chk("wr_oe_at", oe_at - wr_at, 0);
    chk("wr_rdy_count", nrdy, 1);
    chk("wr_rdy_at", rdy_at - wr_at, 3);
`else
    chk("nowr_ack", acks, 1);
    chk("nowr_count", nwr, 0);
    chk("nowr_oe", noe, 0);
    chk("nowr_rdy", nrdy, 0);
`endif
    // reset in the middle of a read: no data_rdy, init reruns
    sdram_req = 1'b1;
    sdram_addr = vec[1].addr;
    a = 0;
    for (int i = 1; i <= 20 && a == 0; i++) begin
      @(negedge clk);
      if (sdram_ack) a = i;
    end
    sdram_req = 1'b0;
    chk("mr_ack", a, 1);
    repeat (2) @(negedge clk);
    run_init(1'b0);
    do_read(0, a, r);
    chk("post_ack_at", a, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtpopeye_sdram.md
JTPOPEYE_SDRAM -- requirements
Module: jtpopeye_sdram

Interface
REQ-001 SHALL have parameters, one per line:
- CL, default 2, CAS latency in clk cycles (2 or 3).
- INIT_WAIT, default 2400, NOP cycles after reset before the init sequence.
- REFRESH_PERIOD, default 390, clk cycles between auto-refresh requests.

REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports, one per line:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- sdram_req  in  1  read request; held by the requester until sdram_ack.
- sdram_addr  in  22  16-bit word address of the read.
- sdram_ack  out  1  one-cycle pulse: request accepted (address latched).
- data_rdy  out  1  one-cycle pulse: data_read valid.
- data_read  out  32  {word[addr+1], word[addr]}.
- refresh_en  in  1  allows auto-refresh issue.
- loop_rst  out  1  high until SDRAM init completes.
- downloading  in  1  ROM download in progress.
- prog_addr  in  22  download word address.
- prog_data  in  16  download word.
- prog_we  in  1  one-cycle download write strobe.
- prog_rdy  out  1  one-cycle pulse: download write done.
- SDRAM_DQ_IN  in  16  data from chip.
- SDRAM_DQ_OUT  out  16  data to chip.
- SDRAM_DQ_OE  out  1  data bus drive enable.
- SDRAM_A  out  13  address pins.
- SDRAM_BA  out  2  bank, always 0.
- SDRAM_CMD  out  4  {nCS,nRAS,nCAS,nWE}: NOP 0111, ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001, MRS 0000.
- SDRAM_DQM  out  2  byte masks, always 0 after reset.

Function
REQ-003 SHALL map addresses as row = addr[21:9] and column = addr[8:0].
REQ-004 Init sequence: INIT_WAIT NOPs; PRE with A10=1; two REFs, each followed by 7 NOPs; MRS with A = burst length 1, sequential, CL; 2 NOPs; loop_rst deasserts on the following cycle.
REQ-005 States SHALL be INIT, IDLE, READ, WRITE, REFRESH; only IDLE accepts new work.
REQ-006 Read timing, relative to T0 = ACT cycle (sdram_ack high at T0):
- T1: NOP.
- T2: READ col with A10=0.
- T3: READ col+1 with A10=1 (auto-precharge).
REQ-007 Each word SHALL be sampled CL+1 cycles after its READ command. data_rdy SHALL pulse one cycle after the second sample, i.e. T(CL+4) (T6 for CL=2). data_read SHALL hold its value until the next data_rdy.
REQ-008 Column+1 SHALL wrap 511 -> 0 within the same row, with no row increment.
REQ-009 The next ACT SHALL come no earlier than 2 cycles after data_rdy (tRP).
REQ-010 Refresh counter: counts clk cycles; at REFRESH_PERIOD it sets a pending flag and restarts. In IDLE, a pending refresh with refresh_en=1 SHALL beat sdram_req: issue REF, then 7 NOPs, then clear the flag. With refresh_en=0 the flag SHALL stay set.
REQ-011 sdram_req while loop_rst=1 SHALL be ignored, with no ack.
REQ-012 SDRAM_DQ_OE SHALL be 0 except in the WRITE data cycle. Unused cycles SHALL issue NOP.

Reset
REQ-013 On rst=1 the block SHALL:
- go to INIT and restart the INIT_WAIT count.
- set loop_rst=1 and SDRAM_CMD=NOP.
- set sdram_ack=0, data_rdy=0, prog_rdy=0, data_read=0, SDRAM_DQ_OE=0, SDRAM_A=0.
- clear the refresh counter and pending flag.
REQ-014 rst mid-read SHALL abandon the access with no data_rdy; the full init sequence SHALL rerun.

Configuration
REQ-015 Macro JTPOPEYE_SDRAM_WRITE_EN.
- Defined: while downloading=1, sdram_req is ignored. In IDLE, prog_we is latched and the block issues ACT, NOP, then WRITE with A10=1, DQ_OUT=prog_data and DQ_OE=1 for that cycle; then 3 NOPs. prog_rdy pulses on the last NOP. Pending refresh beats a write. A prog_we arriving while busy is held until IDLE.
- Undefined: downloading, prog_* and prog_we are ignored; prog_rdy=0 and DQ_OE=0 permanently.

Verification
REQ-016 Reset, then run INIT_WAIT=10 -> command stream PRE, REF, REF, MRS with A=0x020 (CL2, BL1); loop_rst falls exactly 2+1 cycles after MRS.
REQ-017 sdram_addr=0x000A05 read, model returns 0x1234 and 0x5678 -> ACT row 0x5, READ col 0x005 then col 0x006; data_rdy at T6; data_read=0x56781234.
REQ-018 sdram_addr=0x0001FF -> second READ uses col 0x000 in the same row.
REQ-019 Refresh pending and sdram_req asserted together with refresh_en=1 -> REF issued first, ack delayed by 8 cycles; with refresh_en=0 -> read first, REF withheld.
REQ-020 WRITE_EN defined, downloading=1, prog_we with addr 0x000003 and data 0xBEEF -> WRITE col 3 with DQ_OE for one cycle, prog_rdy pulses once; a concurrent sdram_req gets no ack.
